// File: rtl/conv_8x8_out_reader_pkg.sv
// Shared constants, state encoding and pixel bit-offset helper for the 8x8 conv output path.
package conv_8x8_out_reader_pkg;

  localparam int PIX_W   = 9;
  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int FRAME_W = ROWS * COLS * PIX_W;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // MSB bit index of pixel (r,c); row 0 / col 0 live at the top of the packed frame.
  function automatic int pix_offset(input logic [2:0] r, input logic [2:0] c);
    return FRAME_W - 1 - (int'(r) * COLS + int'(c)) * PIX_W;
  endfunction

endpackage

// File: rtl/conv_8x8_pix_mux.sv
// Combinational 64:1 pixel selector over the held frame.
// CONV_OUT_SAT8_EN: when defined, clamps each selected pixel to 8 bits.
module conv_8x8_pix_mux
  import conv_8x8_out_reader_pkg::*;
(
  input  logic [FRAME_W-1:0] frame,
  input  logic [5:0]         idx,
  output logic [PIX_W-1:0]   data
);

  logic [PIX_W-1:0] raw;

  always_comb begin
    raw = frame[pix_offset(idx[5:3], idx[2:0]) -: PIX_W];
  end

`ifdef CONV_OUT_SAT8_EN
  // Anything with bit 8 set exceeds 255, so it clamps to 0x0FF.
  always_comb begin
    data = raw[PIX_W-1] ? 9'h0FF : raw;
  end
`else
  assign data = raw;
`endif

endmodule

// File: rtl/conv_8x8_out_reader.sv
// Captures a packed 8x8 feature map on end_flag and streams it out as 64 raster-ordered pixels.
// CONV_OUT_SAT8_EN (optional) enables 8-bit output saturation inside conv_8x8_pix_mux.
module conv_8x8_out_reader
  import conv_8x8_out_reader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               end_flag,
  input  logic [FRAME_W-1:0] in_frame,
  output logic [PIX_W-1:0]   pix_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [2:0]         pix_row,
  output logic [2:0]         pix_col,
  output logic               pix_last,
  output logic               frame_done,
  output logic               busy,
  output logic               overrun,
  input  logic               ovr_clr
);

  state_t             state;
  logic [5:0]         cnt;
  logic [FRAME_W-1:0] hold;
  logic               hs;
  logic               last_hs;
  logic               drop;

  assign pix_valid = (state == STREAM);
  assign busy      = (state == STREAM);
  assign pix_row   = cnt[5:3];
  assign pix_col   = cnt[2:0];
  assign pix_last  = (cnt == 6'd63);

  assign hs      = pix_valid && pix_ready;
  assign last_hs = hs && pix_last;
  // A frame arriving mid-stream is only accepted if it lines up with the final handshake.
  assign drop    = end_flag && (state == STREAM) && !last_hs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hold       <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= last_hs;
      if (drop) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (end_flag) begin
            hold  <= in_frame;
            cnt   <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (last_hs) begin
            cnt <= '0;
            if (end_flag) begin
              hold <= in_frame;
            end else begin
              state <= IDLE;
            end
          end else if (hs) begin
            cnt <= cnt + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  conv_8x8_pix_mux u_pix_mux (
    .frame (hold),
    .idx   (cnt),
    .data  (pix_data)
  );

endmodule

// File: doc/conv_8x8_out_reader.md
Name: conv_8x8_out_reader

Overview:
- Consumes the packed 8x8 feature map that the 12x12->8x8 convolution stage emits with a one-cycle end_flag pulse.
- Captures the 576-bit frame into a holding register, then streams it out as 64 raster-ordered 9-bit pixels over a valid/ready handshake.
- Sits between the convolution stage and the downstream pooling/serial logic, decoupling the wide parallel result from a narrow consumer.

Parameters:
- PIX_W, 9, bits per output pixel.
- ROWS, 8, feature-map rows.
- COLS, 8, feature-map columns; frame width = ROWS*COLS*PIX_W = 576.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- end_flag  input  1  one-cycle pulse: in_frame valid this cycle.
- in_frame  input  576  packed map; pixel (r,c) at bits [575-(r*COLS+c)*PIX_W -: PIX_W]; row 0 at the MSBs, col 0 at the top of each row.
- pix_data  output  9  current pixel.
- pix_valid  output  1  pix_data/pix_row/pix_col/pix_last are valid.
- pix_ready  input  1  downstream accepts when high together with pix_valid.
- pix_row  output  3  row index of the current pixel.
- pix_col  output  3  column index of the current pixel.
- pix_last  output  1  high with pixel (7,7).
- frame_done  output  1  one-cycle pulse, the cycle after the (7,7) handshake.
- busy  output  1  high while in STREAM.
- overrun  output  1  sticky: a frame was dropped.
- ovr_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE; holding register, pixel counter and all outputs go to 0.
  - Reset asserted mid-stream abandons the frame; no frame_done.
- States:
  - IDLE: pix_valid=0. On end_flag, capture in_frame, clear the counter, go to STREAM.
  - STREAM: pix_valid=1. Each cycle with pix_valid&&pix_ready, the counter increments.
    - On the handshake at count 63, go to IDLE and pulse frame_done in the next cycle.
- Latency: pixel (0,0) is presented with pix_valid high in the cycle after the capturing end_flag.
- Throughput: one pixel per cycle while pix_ready is held high, so 64 cycles per frame.
- Output stability: while pix_valid=1 and pix_ready=0, pix_data, pix_row, pix_col and pix_last hold stable.
- Indexing:
  - Counter is 6 bits; pix_row = cnt[5:3], pix_col = cnt[2:0]; pix_last = (cnt==63).
  - pix_data is a combinational mux of the holding register indexed by cnt.
- Simultaneous end_flag and (7,7) handshake: the new frame is accepted.
  - State stays STREAM and the counter restarts at 0 with the new data.
  - frame_done still pulses next cycle; overrun is not set.
- end_flag in STREAM without a final handshake: the new frame is dropped, the current frame is unaffected, and overrun is set.
- ovr_clr and a new overrun in the same cycle: set wins.
- Overrun clearing: overrun clears only via ovr_clr or reset.
- Arithmetic: no arithmetic on pixel data in the base build; values pass through unsigned and unmodified.

Optional Feature:
- Macro: CONV_OUT_SAT8_EN.
- Defined: pix_data is saturated to 8 bits. Values above 255 output 255 with pix_data[8]=0. The saturation is applied in the output mux, so latency is unchanged.
- Undefined: raw 9-bit value passes through.

Decomposition:
- Shared package holds:
  - Constants PIX_W=9, ROWS=8, COLS=8, FRAME_W=576.
  - State typedef {IDLE, STREAM}.
  - The pixel-offset function (r,c) -> bit index, which the convolution stage also uses.
- One natural sub-module: conv_8x8_pix_mux, the combinational 64:1 PIX_W-bit selector, plus the optional saturation.

Test Plan:
- Frame load, pixel (r,c)=r*8+c (9-bit), end_flag pulse, pix_ready=1:
  - 64 consecutive pixels 0..63 in raster order, starting the cycle after end_flag.
  - pix_last only on value 63; frame_done one cycle later.
- Same frame with pix_ready toggled 1,0,0,1,... (pseudo-random):
  - Every value 0..63 delivered exactly once, in order.
  - Outputs stable during each stall.
- end_flag with all pixels 0x1FF while streaming at pixel 10:
  - overrun=1; remaining original pixels 10..63 unaltered.
  - ovr_clr pulse -> overrun=0 next cycle.
- end_flag coincident with the (7,7) handshake carrying a frame of value 0x100 everywhere:
  - Next cycle pix_valid=1 with pix_data=0x100 at (0,0); frame_done pulses; overrun stays 0.
- Reset driven low at pixel 30:
  - Immediately pix_valid=0, busy=0, overrun=0; no frame_done.
  - After release, a new end_flag streams from (0,0).
- With CONV_OUT_SAT8_EN defined, frame containing 0x1FF, 0x100, 0x0FF, 0x005:
  - Outputs 255, 255, 255, 5.
  - Without the macro: 511, 256, 255, 5.
